// File: rtl/ex_muldiv.sv
// Iterative MIPS-style multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on magnitudes, sign fix-up in a final cycle.
module ex_muldiv #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [1:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_data1,
    input  logic [DATA_WIDTH-1:0] i_data2,
    input  logic                  i_flush,
    input  logic                  i_hi_we,
    input  logic                  i_lo_we,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_div_q, is_div_d;
    logic            neg_q, neg_d;
    logic            rneg_q, rneg_d;
    logic            dz_q, dz_d;
    logic [W-1:0]    opa_q, opa_d;
    logic [W-1:0]    raw_q, raw_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            sgn;
    logic [W-1:0]    mag1, mag2;
    logic [W:0]      sum;
    logic [2*W-1:0]  mul_next;
    logic [W:0]      rem_sh;
    logic [W-1:0]    trial;
    logic            ge;
    logic [2*W-1:0]  div_next;
    logic [2*W-1:0]  mul_res;
    logic [W-1:0]    q_res, r_res;

    always_comb begin
        sgn  = ~i_op[0];
        mag1 = (sgn && i_data1[W-1]) ? -i_data1 : i_data1;
        mag2 = (sgn && i_data2[W-1]) ? -i_data2 : i_data2;

        // acc holds {partial product, remaining multiplier bits}; shifted right each step
        sum      = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opa_q} : '0);
        mul_next = {sum, acc_q[W-1:1]};

        // acc holds {remainder, remaining dividend bits / quotient bits}; shifted left each step
        rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
        ge       = rem_sh >= {1'b0, opa_q};
        trial    = rem_sh[W-1:0] - opa_q;
        div_next = {(ge ? trial : rem_sh[W-1:0]), acc_q[W-2:0], ge};

        mul_res  = neg_q  ? -acc_q            : acc_q;
        q_res    = neg_q  ? -acc_q[W-1:0]     : acc_q[W-1:0];
        r_res    = rneg_q ? -acc_q[2*W-1:W]   : acc_q[2*W-1:W];

        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        opa_d    = opa_q;
        raw_d    = raw_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_hi_we) hi_d = i_wdata;
                if (i_lo_we) lo_d = i_wdata;
                if (i_start && !i_flush) begin
                    state_d  = S_ITER;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    is_div_d = i_op[1];
                    neg_d    = sgn & (i_data1[W-1] ^ i_data2[W-1]);
                    rneg_d   = sgn & i_data1[W-1];
                    dz_d     = (i_data2 == '0);
                    raw_d    = i_data1;
                    if (i_op[1]) begin
                        opa_d = mag2;
                        acc_d = {{W{1'b0}}, mag1};
                    end else begin
                        opa_d = mag1;
                        acc_d = {{W{1'b0}}, mag2};
                    end
                end
            end
            S_ITER: begin
                if (i_flush) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(W - 1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (!i_flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = dz_q ? raw_q : r_res;
                        lo_d = dz_q ? '1    : q_res;
                    end else begin
                        hi_d = mul_res[2*W-1:W];
                        lo_d = mul_res[W-1:0];
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            opa_q    <= '0;
            raw_q    <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            opa_q    <= opa_d;
            raw_q    <= raw_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_hi   = hi_q;
    assign o_lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: stimulus pushes expected HI/LO and accept cycle,
// a negedge monitor pops and checks result, latency and busy length on every o_done.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_data1, i_data2;
    logic        i_flush;
    logic        i_hi_we, i_lo_we;
    logic [31:0] i_wdata;
    logic        o_busy, o_done;
    logic [31:0] o_hi, o_lo;

    ex_muldiv #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_op(i_op),
        .i_data1(i_data1), .i_data2(i_data2), .i_flush(i_flush),
        .i_hi_we(i_hi_we), .i_lo_we(i_lo_we), .i_wdata(i_wdata),
        .o_busy(o_busy), .o_done(o_done), .o_hi(o_hi), .o_lo(o_lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          busy_run = 0;
    logic        done_prev = 1'b0;
    logic [31:0] hi_m, lo_m;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV '/' truncates toward zero, '%' follows the dividend.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb2, qq, rr;
        longint unsigned ua, ub, uq, ur;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        case (op)
            2'b00: return 64'(sa * sb2);
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                qq = sa / sb2;
                rr = sa % sb2;
                return {rr[31:0], qq[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (o_busy) busy_run++;
        if (o_done) begin
            chk("done_single_pulse", {63'd0, done_prev}, 64'd0);
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got o_done=1 expected no pending op (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                chk("hilo", {o_hi, o_lo}, {e.hi, e.lo});
                chk("latency", 64'(cyc - e.acc), 64'd33);
                chk("busy_len", 64'(busy_run), 64'd33);
            end
        end
        if (!o_busy) busy_run = 0;
        done_prev = o_done;
    end

    // Called #1 after a posedge; returns #1 after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
        int          t;
        exp_t        e;
        logic [63:0] r;
        t = 0;
        while (o_busy && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) chk("idle_timeout", 64'(o_busy), 64'd0);
        i_start = 1'b1;
        i_op    = op;
        i_data1 = a;
        i_data2 = b;
        @(posedge clk); #1;
        i_start = 1'b0;
        if (push) begin
            r    = model(op, a, b);
            e.hi = r[63:32];
            e.lo = r[31:0];
            e.acc = cyc;
            sb.push_back(e);
            hi_m = r[63:32];
            lo_m = r[31:0];
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'h1;
            4: return $urandom % 100;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int t;
        rst = 1'b1; i_start = 1'b0; i_op = 2'b00; i_data1 = '0; i_data2 = '0;
        i_flush = 1'b0; i_hi_we = 1'b0; i_lo_we = 1'b0; i_wdata = '0;
        hi_m = '0; lo_m = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {o_hi, o_lo}, 64'd0);
        chk("reset_busy_done", {62'd0, o_busy, o_done}, 64'd0);
        rst = 1'b0;

        // directed vectors; first accepted on first edge after reset release
        issue(2'b00, 32'hFFFFFFFD, 32'h00000005, 1'b1);
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        issue(2'b10, 32'hFFFFFFF9, 32'h00000002, 1'b1);
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        issue(2'b11, 32'h00000064, 32'h00000000, 1'b1);
        issue(2'b10, 32'hFFFFFF9C, 32'h00000000, 1'b1);
        issue(2'b10, 32'h00000007, 32'hFFFFFFFE, 1'b1);

        // MTHI then flushed DIVU; start during ITER ignored
        while (o_busy) begin @(posedge clk); #1; end
        i_hi_we = 1'b1; i_wdata = 32'h12345678;
        @(posedge clk); #1;
        i_hi_we = 1'b0;
        hi_m = 32'h12345678;
        chk("mthi", {32'd0, o_hi}, {32'd0, hi_m});
        issue(2'b11, 32'h00001000, 32'h00000003, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        i_start = 1'b1; i_op = 2'b00; i_data1 = 32'h5; i_data2 = 32'h6;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("busy_in_iter", {63'd0, o_busy}, 64'd1);
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        chk("flush_busy", {63'd0, o_busy}, 64'd0);
        chk("flush_hilo", {o_hi, o_lo}, {hi_m, lo_m});
        repeat (40) begin @(posedge clk); #1; end
        chk("flush_hold_hilo", {o_hi, o_lo}, {hi_m, lo_m});

        // flush on the FIX edge itself
        issue(2'b01, 32'h00000003, 32'h00000007, 1'b0);
        repeat (32) @(posedge clk);
        #1;
        chk("busy_at_fix", {63'd0, o_busy}, 64'd1);
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        chk("fix_flush_done", {62'd0, o_busy, o_done}, 64'd0);
        chk("fix_flush_hilo", {o_hi, o_lo}, {hi_m, lo_m});

        // start with flush in IDLE is ignored
        i_start = 1'b1; i_flush = 1'b1; i_op = 2'b00;
        @(posedge clk); #1;
        i_start = 1'b0; i_flush = 1'b0;
        chk("start_flush_idle", {63'd0, o_busy}, 64'd0);

        // MTLO on the accept edge: write lands, then FIX overwrites
        i_lo_we = 1'b1; i_wdata = 32'hCAFEF00D;
        issue(2'b01, 32'h00010001, 32'h00010001, 1'b1);
        i_lo_we = 1'b0;
        chk("mtlo_with_start", {32'd0, o_lo}, 64'hCAFEF00D);
        // MTHI/MTLO while busy is ignored
        i_hi_we = 1'b1; i_lo_we = 1'b1; i_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        i_hi_we = 1'b0; i_lo_we = 1'b0;
        chk("mt_in_iter", {32'd0, o_lo}, 64'hCAFEF00D);

        // reset mid-MULT, then new MULT right after release
        issue(2'b00, 32'h00000123, 32'hFFFF0000, 1'b0);
        repeat (19) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midop_reset_hilo", {o_hi, o_lo}, 64'd0);
        chk("midop_reset_flags", {62'd0, o_busy, o_done}, 64'd0);
        hi_m = '0; lo_m = '0;
        rst = 1'b0;
        issue(2'b00, 32'hFFFFFFFF, 32'h00000002, 1'b1);

        // randomized ops, occasionally interleaved with MTHI/MTLO in IDLE
        for (int k = 0; k < 40; k++) begin
            issue(2'($urandom), pick(), pick(), 1'b1);
            if ($urandom % 4 == 0) begin
                while (o_busy) begin @(posedge clk); #1; end
                i_lo_we = 1'b1; i_wdata = $urandom;
                @(posedge clk); #1;
                i_lo_we = 1'b0;
                lo_m = i_wdata;
                chk("mtlo_idle", {32'd0, o_lo}, {32'd0, lo_m});
            end
        end

        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
